multi_cycle_control_unit: RTL
=============================

// Module: multi_cycle_control_unit
// PURPOSE
//   Control FSM for the multi-cycle CPU: sequences each instruction through IF/ID/EXE/MEM/WB, one state per clock.
//   Decodes opcode from the instruction register; drives datapath enables/muxes per state.
//   Adds j, a data-memory ready handshake and a sticky halt state.
//   Sits between IR/ALU zero flag and the PC, register file, ALU and data memory.
// PARAMETERS
//   OPCODE_W    6  opcode width (opcode = IR[31:26])
//   ALUOP_W     3  ALU operation select width
//   MEM_WAIT_EN 1  1: MEM state waits for MemReady; 0: MemReady ignored, MEM lasts 1 cycle
// PORTS
//   CLK        in   1         clock, all state changes on rising edge
//   Reset      in   1         synchronous, active-low reset
//   opcode     in   OPCODE_W  opcode from IR; stable from ID onward
//   zero       in   1         ALU zero flag, valid in EXE
//   MemReady   in   1         data memory access complete (MEM state)
//   State      out  3         current state encoding
//   PCWre      out  1         PC load enable (one cycle per instruction)
//   PCSrc      out  2         00 PC+4, 01 PC+4+(imm<<2), 10 jump target
//   IRWre      out  1         IR load enable
//   InsMemRW   out  1         always 0 (instruction memory read-only)
//   ExtSel     out  1         1 sign-extend imm, 0 zero-extend
//   RegOut     out  1         write reg select: 0 rt, 1 rd
//   RegWre     out  1         register file write enable
//   ALUSrcB    out  1         0 rt data, 1 extended imm
//   ALUOp      out  ALUOP_W   000 add, 001 sub, 011 or, 100 and
//   ALUM2Reg   out  1         write-back source: 0 ALU, 1 data memory
//   DataMemRW  out  1         data memory write strobe
//   Halted     out  1         1 while in HALT
// BEHAVIOUR
//   States: IF=000 ID=001 EXE=010 MEM=011 WB=100 HALT=101; state register only sequential element.
//   Reset (Reset==0 at rising edge): next state IF. While Reset==0 all outputs forced 0 (State reads 000).
//   Outputs are combinational from (state, opcode, zero, MemReady); every unlisted output is 0.
//   IF : IRWre=1. -> ID.
//   ID : halt(111111) -> HALT; j(111000) -> IF with PCWre=1, PCSrc=10;
//        add/addi/sub/ori/and/or/move/sw/lw/beq -> EXE; any other opcode -> IF with PCWre=1, PCSrc=00 (NOP).
//   EXE: ALUOp/ALUSrcB/ExtSel per opcode: add,move 000/0/1; addi 000/1/1; sub 001/0/1; ori 011/1/0;
//        and 100/0/0; or 011/0/0; sw,lw 000/1/1; beq 001/0/1.
//        beq: PCWre=1, PCSrc={1'b0,zero} -> IF. sw/lw -> MEM. others -> WB.
//   MEM: ALUOp=000, ALUSrcB=1, ExtSel=1 held. sw: DataMemRW=1 every MEM cycle.
//        Exit when MemReady==1 (or immediately if MEM_WAIT_EN==0): sw -> IF with PCWre=1, PCSrc=00; lw -> WB.
//        MemReady==0 with MEM_WAIT_EN==1: stay in MEM, PCWre=0, no unbounded-wait timeout.
//   WB : RegWre=1, PCWre=1, PCSrc=00 -> IF. RegOut=0 for addi/ori/lw, 1 for R-type/move.
//        ALUM2Reg=1 for lw only; EXE ALU controls held through WB.
//   HALT: Halted=1, PCWre=0, RegWre=0, DataMemRW=0; stays until Reset.
//   Exactly one PCWre pulse per instruction, always in the cycle whose next state is IF.
//   Cycle counts: j/NOP 2, beq 3, R/I-type 4, sw 4, lw 5 (plus MemReady wait cycles).
//   Reset mid-instruction: aborts; no further RegWre/DataMemRW/PCWre; restarts at IF.
//   zero/MemReady are ignored outside EXE/MEM respectively.
// TESTING
//   Reset low 2 cycles, release, opcode=000000 -> states IF,ID,EXE,WB,IF; RegWre=1,PCWre=1,RegOut=1 only in WB.
//   opcode=100111, MemReady low 3 cycles in MEM -> MEM held 3 extra cycles, then WB with ALUM2Reg=1, RegWre=1.
//   opcode=110000, zero=1 in EXE -> PCWre=1, PCSrc=01, next IF; repeat zero=0 -> PCSrc=00; 3 cycles each.
//   opcode=111000 -> ID asserts PCWre=1, PCSrc=10, no EXE; opcode=001111 (undefined) -> NOP, PCWre=1 in ID.
//   opcode=100110, MEM_WAIT_EN=0 with MemReady=0 -> single MEM cycle, DataMemRW=1, PCWre=1, never RegWre.
//   opcode=111111 -> HALT, Halted=1 for 20 cycles, no PCWre; drop Reset during lw MEM -> State=IF next cycle, no RegWre.

Source files
------------

// File: rtl/multi_cycle_control_unit.sv
// Control FSM for a multi-cycle CPU: sequences IF/ID/EXE/MEM/WB, one state per clock,
// and drives the datapath enables and mux selects, with jump, memory-ready wait and halt.
module multi_cycle_control_unit #(
    parameter int unsigned OPCODE_W    = 6,
    parameter int unsigned ALUOP_W     = 3,
    parameter bit          MEM_WAIT_EN = 1'b1
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                MemReady,
    output logic [2:0]          State,
    output logic                PCWre,
    output logic [1:0]          PCSrc,
    output logic                IRWre,
    output logic                InsMemRW,
    output logic                ExtSel,
    output logic                RegOut,
    output logic                RegWre,
    output logic                ALUSrcB,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                ALUM2Reg,
    output logic                DataMemRW,
    output logic                Halted
);

    localparam logic [OPCODE_W-1:0] OpAdd  = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OpSub  = OPCODE_W'(6'b000001);
    localparam logic [OPCODE_W-1:0] OpAddi = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OpOr   = OPCODE_W'(6'b010000);
    localparam logic [OPCODE_W-1:0] OpAnd  = OPCODE_W'(6'b010001);
    localparam logic [OPCODE_W-1:0] OpOri  = OPCODE_W'(6'b010010);
    localparam logic [OPCODE_W-1:0] OpMove = OPCODE_W'(6'b100000);
    localparam logic [OPCODE_W-1:0] OpSw   = OPCODE_W'(6'b100110);
    localparam logic [OPCODE_W-1:0] OpLw   = OPCODE_W'(6'b100111);
    localparam logic [OPCODE_W-1:0] OpBeq  = OPCODE_W'(6'b110000);
    localparam logic [OPCODE_W-1:0] OpJ    = OPCODE_W'(6'b111000);
    localparam logic [OPCODE_W-1:0] OpHalt = OPCODE_W'(6'b111111);

    localparam logic [ALUOP_W-1:0] AluAdd = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] AluSub = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] AluOr  = ALUOP_W'(3'b011);
    localparam logic [ALUOP_W-1:0] AluAnd = ALUOP_W'(3'b100);

    localparam logic [1:0] PcNext   = 2'b00;
    localparam logic [1:0] PcJump   = 2'b10;

    typedef enum logic [2:0] {
        StIf   = 3'b000,
        StId   = 3'b001,
        StExe  = 3'b010,
        StMem  = 3'b011,
        StWb   = 3'b100,
        StHalt = 3'b101
    } state_e;

    state_e state_q, state_d;

    logic [ALUOP_W-1:0] exe_aluop;
    logic               exe_alusrcb;
    logic               exe_extsel;
    logic               op_known;
    logic               is_sw;
    logic               is_lw;
    logic               is_beq;
    logic               mem_done;

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q <= StIf;
        end else begin
            state_q <= state_d;
        end
    end

    // ALU controls per opcode; these are held from EXE through MEM/WB.
    always_comb begin
        exe_aluop   = AluAdd;
        exe_alusrcb = 1'b0;
        exe_extsel  = 1'b0;
        op_known    = 1'b1;
        case (opcode)
            OpAdd, OpMove: begin
                exe_extsel = 1'b1;
            end
            OpAddi, OpSw, OpLw: begin
                exe_alusrcb = 1'b1;
                exe_extsel  = 1'b1;
            end
            OpSub, OpBeq: begin
                exe_aluop  = AluSub;
                exe_extsel = 1'b1;
            end
            OpOri: begin
                exe_aluop   = AluOr;
                exe_alusrcb = 1'b1;
            end
            OpAnd: begin
                exe_aluop = AluAnd;
            end
            OpOr: begin
                exe_aluop = AluOr;
            end
            default: begin
                op_known = 1'b0;
            end
        endcase
    end

    assign is_sw    = (opcode == OpSw);
    assign is_lw    = (opcode == OpLw);
    assign is_beq   = (opcode == OpBeq);
    assign mem_done = !MEM_WAIT_EN || MemReady;

    always_comb begin
        state_d   = state_q;
        State     = state_q;
        PCWre     = 1'b0;
        PCSrc     = PcNext;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        ExtSel    = 1'b0;
        RegOut    = 1'b0;
        RegWre    = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = AluAdd;
        ALUM2Reg  = 1'b0;
        DataMemRW = 1'b0;
        Halted    = 1'b0;

        unique case (state_q)
            StIf: begin
                IRWre   = 1'b1;
                state_d = StId;
            end
            StId: begin
                if (opcode == OpHalt) begin
                    state_d = StHalt;
                end else if (opcode == OpJ) begin
                    PCWre   = 1'b1;
                    PCSrc   = PcJump;
                    state_d = StIf;
                end else if (op_known) begin
                    state_d = StExe;
                end else begin
                    // Undefined opcode retires as a NOP.
                    PCWre   = 1'b1;
                    state_d = StIf;
                end
            end
            StExe: begin
                ALUOp   = exe_aluop;
                ALUSrcB = exe_alusrcb;
                ExtSel  = exe_extsel;
                if (is_beq) begin
                    PCWre   = 1'b1;
                    PCSrc   = {1'b0, zero};
                    state_d = StIf;
                end else if (is_sw || is_lw) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                ALUOp     = AluAdd;
                ALUSrcB   = 1'b1;
                ExtSel    = 1'b1;
                DataMemRW = is_sw;
                if (mem_done) begin
                    if (is_lw) begin
                        state_d = StWb;
                    end else begin
                        PCWre   = 1'b1;
                        state_d = StIf;
                    end
                end
            end
            StWb: begin
                ALUOp    = exe_aluop;
                ALUSrcB  = exe_alusrcb;
                ExtSel   = exe_extsel;
                RegWre   = 1'b1;
                PCWre    = 1'b1;
                RegOut   = !((opcode == OpAddi) || (opcode == OpOri) || is_lw);
                ALUM2Reg = is_lw;
                state_d  = StIf;
            end
            StHalt: begin
                Halted = 1'b1;
            end
            default: begin
                state_d = StIf;
            end
        endcase

        // Outputs are forced quiet while reset is held, whatever the state register holds.
        if (!Reset) begin
            State     = 3'b000;
            PCWre     = 1'b0;
            PCSrc     = PcNext;
            IRWre     = 1'b0;
            ExtSel    = 1'b0;
            RegOut    = 1'b0;
            RegWre    = 1'b0;
            ALUSrcB   = 1'b0;
            ALUOp     = AluAdd;
            ALUM2Reg  = 1'b0;
            DataMemRW = 1'b0;
            Halted    = 1'b0;
        end
    end

endmodule
